// File: rtl/miner_pkg.sv
// Shared types and helpers for the miner datapath stages.
// Holds the block-header geometry, the deserializer state type and the word byte-reversal helper.
package miner_pkg;

    localparam int HDR_WORDS = 20;
    localparam int WORD_W    = 32;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } hdr_state_e;

    // Host little-endian word to SHA-256 big-endian byte order.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/hdr_deserializer.sv
// Pops WORDS FWFT FIFO words into one parallel header and hands it to the SHA core via valid/ready.
// Optional HDR_BSWAP_EN: byte-reverse every captured word.
module hdr_deserializer
    import miner_pkg::*;
#(
    parameter int WORDS = HDR_WORDS,
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           fifo_dout,
    input  logic                       fifo_empty,
    output logic                       fifo_rd_en,
    input  logic                       flush,
    output logic [WORDS*WIDTH-1:0]     hdr_data,
    output logic                       hdr_valid,
    input  logic                       hdr_ready,
    output logic [$clog2(WORDS)-1:0]   word_idx,
    output logic [CNT_W-1:0]           hdr_count
);

    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    hdr_state_e               state_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     valid_q;
    logic [WORDS*WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [WIDTH-1:0]         cap_word_d;

`ifdef HDR_BSWAP_EN
    assign cap_word_d = bswap32(fifo_dout);
`else
    assign cap_word_d = fifo_dout;
`endif

    // Pop only in FILL; flush blocks the pop so nothing is lost in the abort cycle.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (state_q == FILL && !fifo_empty && !flush)
            fifo_rd_en = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= FILL;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (fifo_rd_en) begin
                        data_q[WIDTH*idx_q +: WIDTH] <= cap_word_d;
                        if (idx_q == LAST_IDX) begin
                            state_q <= HOLD;
                            idx_q   <= '0;
                            valid_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (valid_q && hdr_ready) begin
                        valid_q <= 1'b0;
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign hdr_data  = data_q;
    assign hdr_valid = valid_q;
    assign word_idx  = idx_q;
    assign hdr_count = cnt_q;

endmodule
